// File: rtl/bcd_display_scheduler_pkg.sv
// Shared types and constants for the BCD display scheduler.
// Field map, FSM encoding and decode limits.
package bcd_display_scheduler_pkg;

  localparam int NUM_FIELDS_DEF = 9;
  localparam int FIELD_W        = 8;
  localparam int BCD_MAX        = 99;

  localparam int F_SEG  = 0;
  localparam int F_MIN  = 1;
  localparam int F_HOR  = 2;
  localparam int F_DIA  = 3;
  localparam int F_MES  = 4;
  localparam int F_ANO  = 5;
  localparam int F_TSEG = 6;
  localparam int F_TMIN = 7;
  localparam int F_THOR = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SNAP   = 2'd1,
    S_SCAN   = 2'd2,
    S_COMMIT = 2'd3
  } state_e;

endpackage

// File: rtl/bcd_display_scheduler_if.sv
// Field bus between RTC bank, scheduler and digit generators.
// master drives fields/requests; slave is the scheduler.
interface bcd_display_scheduler_if
  import bcd_display_scheduler_pkg::*;
#(
  parameter int NUM_FIELDS = NUM_FIELDS_DEF
);
  logic [NUM_FIELDS*FIELD_W-1:0] field_data;
  logic                          refresh_tick;
  logic                          start;
  logic                          busy;
  logic                          done;
  logic [NUM_FIELDS*FIELD_W-1:0] digits;
  logic [NUM_FIELDS-1:0]         range_err;
  logic                          valid;

  modport master (
    output field_data, refresh_tick, start,
    input  busy, done, digits, range_err, valid
  );

  modport slave (
    input  field_data, refresh_tick, start,
    output busy, done, digits, range_err, valid
  );
endinterface

// File: rtl/bcd_display_scheduler_dec.sv
// Combinational 8-bit binary to two-digit BCD decoder.
// Values above 99 decode to 0/0.
module bcd_display_scheduler_dec
  import bcd_display_scheduler_pkg::*;
(
  input  logic [7:0] bin_i,
  output logic [7:0] bcd_o
);
  logic [3:0] tens;
  logic [3:0] ones;

  // split into tens/ones; out-of-range blanks both digits
  always_comb begin
    tens  = 4'(bin_i / 8'd10);
    ones  = 4'(bin_i % 8'd10);
    bcd_o = {tens, ones};
    if (bin_i > 8'(BCD_MAX))
      bcd_o = 8'h00;
  end
endmodule

// File: rtl/bcd_display_scheduler.sv
// Snapshots all fields, decodes one per cycle through a shared
// decoder, then commits every digit at once.
module bcd_display_scheduler
  import bcd_display_scheduler_pkg::*;
#(
  parameter int NUM_FIELDS = NUM_FIELDS_DEF
)(
  input logic                    clk,
  input logic                    reset,
  bcd_display_scheduler_if.slave bus
);
  localparam int IW = $clog2(NUM_FIELDS);
  localparam int DW = NUM_FIELDS * FIELD_W;
  localparam logic [IW-1:0] LAST = IW'(NUM_FIELDS - 1);

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q;
  logic                  pend_q;
  logic                  done_q;
  logic                  valid_q;
  logic [DW-1:0]         snap_q;
  logic [DW-1:0]         stage_q;
  logic [NUM_FIELDS-1:0] err_q;
  logic [DW-1:0]         digits_q;
  logic [NUM_FIELDS-1:0] rerr_q;
  logic                  req;
  logic [FIELD_W-1:0]    dec_in;
  logic [7:0]            dec_out;

  assign req    = bus.start | bus.refresh_tick;
  assign dec_in = snap_q[idx_q*FIELD_W +: FIELD_W];

  bcd_display_scheduler_dec u_dec (
    .bin_i (dec_in),
    .bcd_o (dec_out)
  );

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next-state: snapshot, walk every field, commit
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (req || pend_q) state_d = S_SNAP;
      S_SNAP:   state_d = S_SCAN;
      S_SCAN:   if (idx_q == LAST) state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
    endcase
  end

  // datapath: pending merge, snapshot, staging, atomic commit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q    <= '0;
      pend_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      snap_q   <= '0;
      stage_q  <= '0;
      err_q    <= '0;
      digits_q <= '0;
      rerr_q   <= '0;
    end else begin
      done_q <= 1'b0;
      pend_q <= (state_q == S_IDLE) ? 1'b0 : (pend_q | req);
      unique case (state_q)
        S_IDLE: ;
        S_SNAP: begin
          snap_q <= bus.field_data;
          idx_q  <= '0;
        end
        S_SCAN: begin
          stage_q[idx_q*FIELD_W +: FIELD_W] <= dec_out;
          err_q[idx_q] <= dec_in > FIELD_W'(BCD_MAX);
          if (idx_q != LAST) idx_q <= idx_q + IW'(1);
        end
        S_COMMIT: begin
          digits_q <= stage_q;
          rerr_q   <= err_q;
          done_q   <= 1'b1;
          valid_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.busy      = (state_q != S_IDLE) | done_q;
  assign bus.done      = done_q;
  assign bus.digits    = digits_q;
  assign bus.range_err = rerr_q;
  assign bus.valid     = valid_q;
endmodule

// File: tb/tb_bcd_display_scheduler.sv
// Scoreboard bench for bcd_display_scheduler.
// Stimulus pushes expected commits; monitor checks on done.
module tb_bcd_display_scheduler;
  import bcd_display_scheduler_pkg::*;

  localparam int NF = 9;

  typedef struct {
    logic [71:0] dig;
    logic [8:0]  err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_display_scheduler_if #(.NUM_FIELDS(NF)) bus ();

  bcd_display_scheduler #(.NUM_FIELDS(NF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic chk(input string nm, input logic [71:0] act,
                     input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit s, input bit r);
    bus.start        = s;
    bus.refresh_tick = r;
    tick(1);
    bus.start        = 1'b0;
    bus.refresh_tick = 1'b0;
  endtask

  task automatic expect_pass(input logic [71:0] d, input logic [8:0] e,
                             input int c);
    exp_t x;
    x.dig = d;
    x.err = e;
    x.cyc = c;
    q.push_back(x);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || bus.busy) && n < 100) begin
      tick(1);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL wait_idle timeout got q=%0d busy=%b want empty/0",
               q.size(), bus.busy);
    end
  endtask

  // monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (reset && bus.done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got done=1 want no pass at cyc %0d",
                 cyc);
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("digits", bus.digits, x.dig);
        chk("range_err", 72'(bus.range_err), 72'(x.err));
        chk("valid", 72'(bus.valid), 72'(1'b1));
        chk("busy_at_done", 72'(bus.busy), 72'(1'b1));
        chk("done_cycle", 72'(cyc), 72'(x.cyc));
      end
    end
  end

  logic [71:0] d1;

  initial begin
    bus.field_data   = '0;
    bus.start        = 1'b0;
    bus.refresh_tick = 1'b0;
    reset            = 1'b0;
    tick(3);
    chk("rst_digits", bus.digits, 72'h0);
    chk("rst_valid", 72'(bus.valid), 72'h0);
    chk("rst_busy", 72'(bus.busy), 72'h0);
    chk("rst_done", 72'(bus.done), 72'h0);
    chk("rst_err", 72'(bus.range_err), 72'h0);
    reset = 1'b1;
    tick(2);

    // normal clock/date fields
    bus.field_data = {8'd1, 8'd5, 8'd0, 8'd16, 8'd12, 8'd31,
                      8'd23, 8'd59, 8'd7};
    d1 = {8'h01, 8'h05, 8'h00, 8'h16, 8'h12, 8'h31,
          8'h23, 8'h59, 8'h07};
    expect_pass(d1, 9'h0, cyc + 12);
    pulse(1'b1, 1'b0);
    chk("busy_after_req", 72'(bus.busy), 72'h1);
    wait_idle();
    chk("busy_after_done", 72'(bus.busy), 72'h0);

    // out-of-range month; digits must hold during scan
    bus.field_data = {8'd0, 8'd0, 8'd0, 8'd0, 8'd150, 8'd0,
                      8'd0, 8'd0, 8'd0};
    expect_pass(72'h0, 9'b0_0001_0000, cyc + 12);
    pulse(1'b1, 1'b0);
    tick(4);
    chk("midscan_digits", bus.digits, d1);
    chk("midscan_err", 72'(bus.range_err), 72'h0);
    wait_idle();

    // boundaries: 99 legal, 100 and 255 flagged
    bus.field_data = {8'd99, 8'd0, 8'd0, 8'd255, 8'd0, 8'd100,
                      8'd0, 8'd10, 8'd9};
    expect_pass({8'h99, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h10, 8'h09}, 9'b0_0010_1000, cyc + 12);
    pulse(1'b1, 1'b0);
    wait_idle();

    // field changes after snapshot do not leak into the pass
    bus.field_data = {64'h0, 8'd10};
    expect_pass({64'h0, 8'h10}, 9'h0, cyc + 12);
    pulse(1'b1, 1'b0);
    tick(2);
    bus.field_data = {64'h0, 8'd11};
    wait_idle();
    expect_pass({64'h0, 8'h11}, 9'h0, cyc + 12);
    pulse(1'b0, 1'b1);
    wait_idle();

    // two refreshes during a pass merge into one extra pass
    bus.field_data = {48'h0, 8'd12, 8'd34, 8'd56};
    expect_pass({48'h0, 8'h12, 8'h34, 8'h56}, 9'h0, cyc + 12);
    expect_pass({48'h0, 8'h98, 8'h76, 8'h54}, 9'h0, cyc + 24);
    pulse(1'b1, 1'b0);
    tick(3);
    bus.field_data = {48'h0, 8'd98, 8'd76, 8'd54};
    pulse(1'b0, 1'b1);
    tick(1);
    pulse(1'b0, 1'b1);
    wait_idle();

    // simultaneous start and refresh is one request
    bus.field_data = {8'd42, 64'h0};
    expect_pass({8'h42, 64'h0}, 9'h0, cyc + 12);
    pulse(1'b1, 1'b1);
    wait_idle();
    tick(15);

    // reset mid-pass discards the partial pass
    bus.field_data = {64'h0, 8'd77};
    pulse(1'b1, 1'b0);
    tick(5);
    reset = 1'b0;
    #2;
    chk("midrst_digits", bus.digits, 72'h0);
    chk("midrst_valid", 72'(bus.valid), 72'h0);
    chk("midrst_busy", 72'(bus.busy), 72'h0);
    chk("midrst_err", 72'(bus.range_err), 72'h0);
    tick(1);
    reset = 1'b1;
    tick(20);
    chk("post_rst_valid", 72'(bus.valid), 72'h0);
    bus.field_data = {40'h0, 8'd88, 16'h0, 8'd77};
    expect_pass({40'h0, 8'h88, 16'h0, 8'h77}, 9'h0, cyc + 12);
    pulse(1'b1, 1'b0);
    wait_idle();
    tick(3);
    chk("queue_empty", 72'(q.size()), 72'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
